// File: rtl/npu_seq_ctrl.sv
// rtl/npu_seq_ctrl.sv - job sequencer for the 3x3 int8 systolic PE array
// Clears the array, feeds skewed input lanes, deskews column sums into the output buffer.
module npu_seq_ctrl #(
    parameter int AW  = 4,
    parameter int LAT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] n_vec,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          in_rd_en,
    output logic [AW-1:0] in_rd_addr,
    input  logic [23:0]   in_rd_data,
    output logic          clr_o,
    output logic          en_o,
    output logic [7:0]    left0,
    output logic [7:0]    left1,
    output logic [7:0]    left2,
    input  logic [15:0]   col0,
    input  logic [15:0]   col1,
    input  logic [15:0]   col2,
    output logic          out_we,
    output logic [AW-1:0] out_addr,
    output logic [47:0]   out_data
);
    localparam int DW = $clog2(LAT);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t          state;
    logic [AW-1:0]   n_reg;
    logic [DW-1:0]   drain_cnt;
    logic            rd_vld;
    logic [LAT-1:0]  vld_pipe;
    logic [7:0]      lane1_d;
    logic [7:0]      lane2_d0;
    logic [7:0]      lane2_d1;
    logic [15:0]     col0_d0;
    logic [15:0]     col0_d1;
    logic [15:0]     col1_d0;
    logic            adv;

    // hold freezes everything downstream of IDLE, so every strobe is gated by it
    assign adv      = !hold;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE) && adv;
    assign clr_o    = (state == S_CLEAR) && adv;
    assign in_rd_en = (state == S_FEED) && adv;
    assign en_o     = ((state == S_FEED) || (state == S_DRAIN)) && adv;
    assign out_we   = vld_pipe[LAT-1] && adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            n_reg      <= '0;
            drain_cnt  <= '0;
            rd_vld     <= 1'b0;
            vld_pipe   <= '0;
            in_rd_addr <= '0;
            out_addr   <= '0;
            out_data   <= '0;
            left0      <= '0;
            left1      <= '0;
            left2      <= '0;
            lane1_d    <= '0;
            lane2_d0   <= '0;
            lane2_d1   <= '0;
            col0_d0    <= '0;
            col0_d1    <= '0;
            col1_d0    <= '0;
        end else begin
            if (adv) begin
                // vld_pipe tracks each issued read to its aligned write slot
                rd_vld   <= (state == S_FEED);
                vld_pipe <= {vld_pipe[LAT-2:0], state == S_FEED};
                left0    <= rd_vld ? in_rd_data[7:0]   : 8'd0;
                lane1_d  <= rd_vld ? in_rd_data[15:8]  : 8'd0;
                lane2_d0 <= rd_vld ? in_rd_data[23:16] : 8'd0;
                left1    <= lane1_d;
                lane2_d1 <= lane2_d0;
                left2    <= lane2_d1;
                col0_d0  <= col0;
                col0_d1  <= col0_d0;
                col1_d0  <= col1;
                out_data <= {col2, col1_d0, col0_d1};
                if (vld_pipe[LAT-1]) begin
                    out_addr <= out_addr + AW'(1);
                end
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_reg      <= n_vec;
                        in_rd_addr <= '0;
                        out_addr   <= '0;
                        drain_cnt  <= '0;
                        state      <= (n_vec != '0) ? S_CLEAR : S_DONE;
                    end
                end
                S_CLEAR: begin
                    if (adv) begin
                        state <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (adv) begin
                        if (in_rd_addr == n_reg - AW'(1)) begin
                            in_rd_addr <= '0;
                            drain_cnt  <= '0;
                            state      <= S_DRAIN;
                        end else begin
                            in_rd_addr <= in_rd_addr + AW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (adv) begin
                        if (drain_cnt == DW'(LAT - 1)) begin
                            state <= S_DONE;
                        end else begin
                            drain_cnt <= drain_cnt + DW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (adv) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_npu_seq_ctrl.sv
// tb/tb_npu_seq_ctrl.sv - directed bench with buffer/array models and result scoreboard
module tb_npu_seq_ctrl;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic [AW-1:0] n_vec = '0;
    logic [23:0]   in_rd_data = '0;
    logic [15:0]   col0 = '0;
    logic [15:0]   col1 = '0;
    logic [15:0]   col2 = '0;
    logic          busy, done, in_rd_en, clr_o, en_o, out_we;
    logic [AW-1:0] in_rd_addr, out_addr;
    logic [7:0]    left0, left1, left2;
    logic [47:0]   out_data;

    npu_seq_ctrl #(.AW(AW), .LAT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .n_vec(n_vec), .hold(hold),
        .busy(busy), .done(done), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
        .in_rd_data(in_rd_data), .clr_o(clr_o), .en_o(en_o),
        .left0(left0), .left1(left1), .left2(left2),
        .col0(col0), .col1(col1), .col2(col2),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    logic [23:0]       mem [16];
    logic signed [7:0] w [3][3];
    logic signed [7:0] hist [3][64];
    int                ak = 0;

    // Array model: col c at enabled step k sums row r inputs from step k-(c+2)+r
    function automatic logic [15:0] acol(input int c, input int k, input logic [23:0] cur);
        int s;
        int idx;
        logic signed [7:0] v;
        s = 0;
        for (int r = 0; r < 3; r++) begin
            idx = k - (c + 2) + r;
            if (idx == k) v = cur[8*r +: 8];
            else if (idx >= 0) v = hist[r][idx];
            else v = 8'sd0;
            s += int'(v) * int'(w[r][c]);
        end
        return s[15:0];
    endfunction

    always @(posedge clk) begin
        if (in_rd_en) in_rd_data <= mem[in_rd_addr];
        if (rst || clr_o) begin
            ak   <= 0;
            col0 <= '0;
            col1 <= '0;
            col2 <= '0;
        end else if (en_o && ak < 64) begin
            hist[0][ak] <= left0;
            hist[1][ak] <= left1;
            hist[2][ak] <= left2;
            col0 <= acol(0, ak, {left2, left1, left0});
            col1 <= acol(1, ak, {left2, left1, left0});
            col2 <= acol(2, ak, {left2, left1, left0});
            ak   <= ak + 1;
        end
    end

    function automatic logic [47:0] gold(input int v);
        logic [47:0] res;
        logic signed [7:0] b;
        int s;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            s = 0;
            for (int r = 0; r < 3; r++) begin
                b = mem[v][8*r +: 8];
                s += int'(b) * int'(w[r][c]);
            end
            res[16*c +: 16] = s[15:0];
        end
        return res;
    endfunction

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int s_cyc, f0, first_we, done_cyc;
    int busy_c, clr_c, rd_c, we_c, done_c, dup_c, max_addr;
    int hits [16];
    bit hold_plan [100];
    logic [51:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        logic [51:0] e;
        cyc++;
        if (busy) busy_c++;
        if (clr_o) clr_c++;
        if (in_rd_en) begin
            rd_c++;
            if (f0 < 0) f0 = cyc;
        end
        if (busy && int'(in_rd_addr) > max_addr) max_addr = int'(in_rd_addr);
        if (done) begin
            done_c++;
            done_cyc = cyc;
        end
        if (out_we) begin
            we_c++;
            if (first_we < 0) first_we = cyc;
            if (hits[out_addr] != 0) dup_c++;
            hits[out_addr]++;
            if (exp_q.size() == 0) begin
                chk("sb_extra_we", 64'(out_we), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", 64'(out_addr), 64'(e[51:48]));
                chk("sb_data", 64'(out_data), 64'(e[47:0]));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        f0 = -1; first_we = -1; done_cyc = -1;
        busy_c = 0; clr_c = 0; rd_c = 0; we_c = 0; done_c = 0; dup_c = 0; max_addr = 0;
        for (int i = 0; i < 16; i++) hits[i] = 0;
    endtask

    task automatic fill(input int n, input bit rnd);
        for (int v = 0; v < 16; v++) mem[v] = rnd ? 24'($urandom) : {8'd3, 8'd2, 8'd1};
        for (int v = 0; v < n; v++) exp_q.push_back({AW'(v), gold(v)});
    endtask

    task automatic run_job(input int n, input bit spam, input bit hold_s);
        clear_stats();
        start = 1'b1; n_vec = AW'(n); hold = hold_s;
        tick();
        s_cyc = cyc;
        start = spam; hold = 1'b0;
        for (int i = 0; i < 100 && done_c == 0; i++) begin
            hold = hold_plan[i];
            tick();
        end
        start = 1'b0; hold = 1'b0;
        tick(); tick(); tick();
        chk("done_once", 64'(done_c), 64'd1);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chk("dup_writes", 64'(dup_c), 64'd0);
        chk("idle_after", 64'(busy), 64'd0);
        chk("write_count", 64'(we_c), 64'(n));
        exp_q.delete();
        for (int i = 0; i < 100; i++) hold_plan[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 100; i++) hold_plan[i] = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) w[r][c] = (r == c) ? 8'sd1 : 8'sd0;
        @(posedge clk); #1;
        clear_stats();
        rst = 1'b1;
        tick(); tick();
        chk("reset_ctrl", 64'({busy, done, in_rd_en, clr_o, en_o, out_we}), 64'd0);
        chk("reset_regs", 64'({left0, left1, left2, in_rd_addr, out_addr}), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        tick();

        // n=4 constant vectors, identity weights: fixed latency and job length
        fill(4, 1'b0);
        run_job(4, 1'b0, 1'b0);
        chk("t1_f0_offset", 64'(f0 - s_cyc), 64'd2);
        chk("t1_first_we", 64'(first_we - f0), 64'd8);
        chk("t1_done", 64'(done_cyc - f0), 64'd12);
        chk("t1_busy", 64'(busy_c), 64'd14);
        chk("t1_clr", 64'(clr_c), 64'd1);
        chk("t1_reads", 64'(rd_c), 64'd4);

        // n=0: straight to done
        run_job(0, 1'b0, 1'b0);
        chk("t2_done", 64'(done_cyc - s_cyc), 64'd1);
        chk("t2_busy", 64'(busy_c), 64'd1);
        chk("t2_clr", 64'(clr_c), 64'd0);
        chk("t2_reads", 64'(rd_c), 64'd0);

        // max job, random data and weights
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) w[r][c] = 8'($urandom);
        fill(15, 1'b1);
        run_job(15, 1'b0, 1'b0);
        chk("t3_max_addr", 64'(max_addr), 64'd14);
        chk("t3_reads", 64'(rd_c), 64'd15);
        chk("t3_done", 64'(done_cyc - s_cyc), 64'd25);

        // 1- and 3-cycle holds in FEED and in DRAIN: 8 cycles of delay
        fill(6, 1'b1);
        hold_plan[2] = 1'b1;
        for (int i = 4; i <= 6; i++) hold_plan[i] = 1'b1;
        hold_plan[13] = 1'b1;
        for (int i = 15; i <= 17; i++) hold_plan[i] = 1'b1;
        run_job(6, 1'b0, 1'b0);
        chk("t4_done", 64'(done_cyc - s_cyc), 64'd24);
        chk("t4_reads", 64'(rd_c), 64'd6);

        // start accepted under hold; CLEAR waits two cycles
        fill(3, 1'b1);
        hold_plan[0] = 1'b1;
        hold_plan[1] = 1'b1;
        run_job(3, 1'b0, 1'b1);
        chk("t5_done", 64'(done_cyc - s_cyc), 64'd15);
        chk("t5_clr", 64'(clr_c), 64'd1);

        // start held high for the whole job: one job only
        fill(5, 1'b1);
        run_job(5, 1'b1, 1'b0);
        chk("t6_busy", 64'(busy_c), 64'd15);
        chk("t6_clr", 64'(clr_c), 64'd1);

        // reset in the middle of FEED, then a fresh 2-vector job
        fill(0, 1'b1);
        clear_stats();
        start = 1'b1; n_vec = AW'(8);
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t7_in_feed", 64'(in_rd_en), 64'd1);
        rst = 1'b1;
        tick();
        chk("t7_rst_ctrl", 64'({busy, done, in_rd_en, clr_o, en_o, out_we}), 64'd0);
        chk("t7_rst_addr", 64'({in_rd_addr, out_addr, left0}), 64'd0);
        rst = 1'b0;
        tick(); tick();
        chk("t7_no_done", 64'(done_c), 64'd0);
        fill(2, 1'b1);
        run_job(2, 1'b0, 1'b0);
        chk("t7_done", 64'(done_cyc - s_cyc), 64'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
